// File: rtl/apb_spi_master.sv
// apb_spi_master: APB-programmed SPI master (mode 0) that issues one single-word
// remote write or read per START, framed as CMD(8) / ADDR / [dummy] / DATA, MSB first.
//
// Build option: define SPI_MASTER_IRQ_EN to add irq_o and the CTRL.IRQ_EN bit.
//
// Ports:
//   apb_pclk_i, apb_preset_i       clock, asynchronous active-high reset
//   apb_psel_i .. apb_pslverr_o    APB slave (zero wait states, pready tied 1)
//   spi_sclk_o, spi_cs_o           SPI clock (idle low), chip select (active low)
//   spi_mosi_o, spi_miso_i         SPI data out / in
//   irq_o                          (SPI_MASTER_IRQ_EN only) DONE & IRQ_EN, registered
//
// Register map (paddr[4:2]): 0x00 CTRL, 0x04 ADDR, 0x08 TXDATA, 0x0C RXDATA (RO),
// 0x10 STATUS {DONE(W1C), BUSY}, 0x14 CLKDIV. SCLK half period = CLKDIV+1 pclk.
module apb_spi_master #(
  parameter int APB_ADDR_WIDTH    = 12,
  parameter int SPI_ADDR_WIDTH    = 12,
  parameter int SPI_DATA_WIDTH    = 8,
  parameter int READ_DUMMY_CYCLES = 8,
  parameter int CLK_DIV_WIDTH     = 8
) (
  input  logic                      apb_pclk_i,
  input  logic                      apb_preset_i,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic                      apb_pwrite_i,
  input  logic [31:0]               apb_pwdata_i,
  output logic [31:0]               apb_prdata_o,
  output logic                      apb_pready_o,
  output logic                      apb_pslverr_o,
`ifdef SPI_MASTER_IRQ_EN
  output logic                      irq_o,
`endif
  output logic                      spi_sclk_o,
  output logic                      spi_cs_o,
  output logic                      spi_mosi_o,
  input  logic                      spi_miso_i
);

  localparam int SR_W      = 8 + SPI_ADDR_WIDTH + SPI_DATA_WIDTH;
  localparam int BITS_RD_I = SR_W + READ_DUMMY_CYCLES;
  localparam int CNT_W     = $clog2(BITS_RD_I + 1);

  localparam logic [CNT_W-1:0] BITS_WR   = CNT_W'(SR_W);
  localparam logic [CNT_W-1:0] BITS_RD   = CNT_W'(BITS_RD_I);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(SPI_DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(1);

  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h0B;

  localparam logic [2:0] OFS_CTRL   = 3'd0;
  localparam logic [2:0] OFS_ADDR   = 3'd1;
  localparam logic [2:0] OFS_TXDATA = 3'd2;
  localparam logic [2:0] OFS_RXDATA = 3'd3;
  localparam logic [2:0] OFS_STATUS = 3'd4;
  localparam logic [2:0] OFS_CLKDIV = 3'd5;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                    state, state_nx;
  logic                      ctrl_rw;
  logic                      irq_en;
  logic [SPI_ADDR_WIDTH-1:0] addr_reg;
  logic [SPI_DATA_WIDTH-1:0] tx_reg;
  logic [SPI_DATA_WIDTH-1:0] rx_reg;
  logic [SPI_DATA_WIDTH-1:0] rx_shift;
  logic [SPI_DATA_WIDTH-1:0] tx_load;
  logic [CLK_DIV_WIDTH-1:0]  clkdiv;
  logic [CLK_DIV_WIDTH-1:0]  hcnt;
  logic [SR_W-1:0]           sr;
  logic [CNT_W-1:0]          bitcnt;
  logic                      sclk;
  logic                      done;
  logic                      busy;
  logic                      tick;
  logic                      access;
  logic                      err;
  logic                      wr_en;
  logic                      start;
  logic [2:0]                reg_idx;
  logic [31:0]               rdata;
  logic                      unused_bits;

  assign unused_bits = ^{apb_paddr_i, apb_pwdata_i};

  assign reg_idx = apb_paddr_i[4:2];
  assign access  = apb_psel_i & apb_penable_i;
  assign busy    = (state != IDLE);
  assign tick    = (hcnt == clkdiv);
  assign wr_en   = access & apb_pwrite_i & ~err;
  // err already rejects CTRL writes while busy, so start only fires from IDLE
  assign start   = wr_en & (reg_idx == OFS_CTRL) & apb_pwdata_i[0];
  assign tx_load = apb_pwdata_i[1] ? '0 : tx_reg;

  always_comb begin
    err = 1'b0;
    case (reg_idx)
      OFS_CTRL, OFS_ADDR, OFS_TXDATA, OFS_CLKDIV: err = apb_pwrite_i & busy;
      OFS_RXDATA:                                 err = apb_pwrite_i;
      OFS_STATUS:                                 err = 1'b0;
      default:                                    err = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      OFS_CTRL: begin
        rdata[1] = ctrl_rw;
        rdata[2] = irq_en;
      end
      OFS_ADDR:   rdata[SPI_ADDR_WIDTH-1:0] = addr_reg;
      OFS_TXDATA: rdata[SPI_DATA_WIDTH-1:0] = tx_reg;
      OFS_RXDATA: rdata[SPI_DATA_WIDTH-1:0] = rx_reg;
      OFS_STATUS: begin
        rdata[0] = busy;
        rdata[1] = done;
      end
      OFS_CLKDIV: rdata[CLK_DIV_WIDTH-1:0] = clkdiv;
      default:    rdata = '0;
    endcase
  end

  assign apb_prdata_o  = (access & ~apb_pwrite_i) ? rdata : '0;
  assign apb_pslverr_o = access & err;
  assign apb_pready_o  = 1'b1;

  // State register
  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) state <= IDLE;
    else              state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = SETUP;
      SETUP: if (tick) state_nx = SHIFT;
      // leave on the falling edge that retires the last bit
      SHIFT: if (tick && sclk && (bitcnt == LAST_BIT)) state_nx = HOLD;
      HOLD:  if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: cs follows the state so an asynchronous reset releases it at once
  assign spi_cs_o   = (state == IDLE);
  assign spi_sclk_o = sclk;
  assign spi_mosi_o = sr[SR_W-1];

  // Register file and shift datapath
  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) begin
      ctrl_rw  <= 1'b0;
      irq_en   <= 1'b0;
      addr_reg <= '0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      rx_shift <= '0;
      clkdiv   <= CLK_DIV_WIDTH'(1);
      hcnt     <= '0;
      sr       <= '0;
      bitcnt   <= '0;
      sclk     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_idx)
          OFS_CTRL: begin
            ctrl_rw <= apb_pwdata_i[1];
`ifdef SPI_MASTER_IRQ_EN
            irq_en  <= apb_pwdata_i[2];
`endif
          end
          OFS_ADDR:   addr_reg <= apb_pwdata_i[SPI_ADDR_WIDTH-1:0];
          OFS_TXDATA: tx_reg   <= apb_pwdata_i[SPI_DATA_WIDTH-1:0];
          OFS_STATUS: if (apb_pwdata_i[1]) done <= 1'b0;
          OFS_CLKDIV: clkdiv   <= apb_pwdata_i[CLK_DIV_WIDTH-1:0];
          default: ;
        endcase
      end

      if (state == IDLE || tick) hcnt <= '0;
      else                       hcnt <= hcnt + 1'b1;

      // FSM updates come after the W1C above so a same-edge DONE set wins
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          if (start) begin
            sr       <= {(apb_pwdata_i[1] ? CMD_RD : CMD_WR), addr_reg, tx_load};
            bitcnt   <= apb_pwdata_i[1] ? BITS_RD : BITS_WR;
            rx_shift <= '0;
            done     <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!sclk) begin
              if (ctrl_rw && (bitcnt <= DATA_BITS))
                rx_shift <= {rx_shift[SPI_DATA_WIDTH-2:0], spi_miso_i};
            end else begin
              sr     <= {sr[SR_W-2:0], 1'b0};
              bitcnt <= bitcnt - 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (ctrl_rw) rx_reg <= rx_shift;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  always_ff @(posedge apb_pclk_i or posedge apb_preset_i) begin
    if (apb_preset_i) irq_o <= 1'b0;
    else              irq_o <= done & irq_en;
  end
`endif

endmodule
